fifo_reader: RTL and testbench

Single-clock read-side controller that drains a synchronous FIFO in bursts and presents the words as a valid/ready stream. A burst starts on a command pulse carrying a word count. The block issues FIFO read strobes under a credit scheme that matches the FIFO's one-cycle read latency, and buffers the returned data in a 2-entry skid buffer. It sits between the FIFO read port (`clk_rd_i` domain) and any downstream consumer, and signals burst completion with a one-cycle pulse.

---
 rtl/fifo_reader_pkg.sv | 25 ++
 rtl/fifo_reader_skid.sv | 59 +++++
 rtl/fifo_reader.sv | 146 ++++++++++++++
 tb/tb_fifo_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types for the burst FIFO reader.
//   fifo_reader_state_t : controller FSM states (ABORT only with FIFO_READER_TIMEOUT_EN)
//   SKID_DEPTH          : entries in the output skid buffer
//   skid_entry_t        : default buffered word {data, last}
package fifo_reader_pkg;

  localparam int SKID_DEPTH      = 2;
  localparam int SKID_DATA_WIDTH = 18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3
`ifdef FIFO_READER_TIMEOUT_EN
    , ST_ABORT = 3'd4
`endif
  } fifo_reader_state_t;

  typedef struct packed {
    logic [SKID_DATA_WIDTH-1:0] data;
    logic                       last;
  } skid_entry_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry skid buffer, no knowledge of bursts.
//   clk_rd_i, rst_n_i : clock, async active-low reset
//   push_i/push_entry_i : write one entry (caller guarantees no overflow)
//   valid_o/ready_i/head_o : valid/ready output of the oldest entry
//   pop_o  : head accepted this cycle (valid_o && ready_i)
//   occ_o  : current occupancy 0..2
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter type entry_t = skid_entry_t
) (
  input  logic       clk_rd_i,
  input  logic       rst_n_i,
  input  logic       push_i,
  input  entry_t     push_entry_i,
  output logic       valid_o,
  input  logic       ready_i,
  output entry_t     head_o,
  output logic       pop_o,
  output logic [1:0] occ_o
);

  entry_t [SKID_DEPTH-1:0] mem_q;   // mem_q[0] is always the head
  logic   [1:0]            occ_q;

  assign valid_o = (occ_q != 2'd0);
  assign pop_o   = valid_o && ready_i;
  assign head_o  = mem_q[0];
  assign occ_o   = occ_q;

  always_ff @(posedge clk_rd_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q <= '0;
      occ_q <= 2'd0;
    end else begin
      case ({push_i, pop_o})
        2'b10: begin
          mem_q[occ_q[0]] <= push_entry_i;
          occ_q           <= occ_q + 2'd1;
        end
        2'b01: begin
          mem_q[0] <= mem_q[1];
          occ_q    <= occ_q - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; new word lands behind whatever remains
          if (occ_q == 2'd1) begin
            mem_q[0] <= push_entry_i;
          end else begin
            mem_q[0] <= mem_q[1];
            mem_q[1] <= push_entry_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains a synchronous FIFO (1-cycle read latency) in bursts
// and presents the words as a valid/ready stream.
//   clk_rd_i, rst_n_i     : clock, async active-low reset
//   start_i, len_i        : burst command (accepted only in IDLE)
//   fifo_empty_i, fifo_data_i, rd_o, oe_o : FIFO read port
//   m_valid_o, m_ready_i, m_data_o, m_last_o : output stream
//   busy_o, done_o, err_o : status (err_o = sticky timeout abort)
// Optional macro FIFO_READER_TIMEOUT_EN adds an empty-FIFO timeout that
// aborts the burst; without it err_o is 0 and bursts wait indefinitely.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = 18,
  parameter int LEN_WIDTH      = 11,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_rd_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  rd_o,
  output logic                  oe_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  fifo_reader_state_t   state_q, state_d;
  logic [LEN_WIDTH-1:0] remain_q;
  logic                 infl_q;       // strobe issued last cycle, data arrives now
  logic                 infl_last_q;  // that strobe was the burst's final one
  logic [1:0]           occ;
  logic                 pop, skid_valid;
  entry_t               head, push_entry;
  logic [2:0]           credit_sum;
  logic                 credit_ok, drained;

  // Slots claimed after this cycle must stay below the buffer depth so the
  // word of a strobe issued now always has room when it returns.
  assign credit_sum = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
  assign credit_ok  = (credit_sum < 3'd2);
  assign rd_o       = (state_q == ST_READ) && !fifo_empty_i &&
                      (remain_q != '0) && credit_ok;

  // Empty after this cycle: lets done_o follow the final pop by one cycle.
  assign drained = !infl_q && ((occ == 2'd0) || (occ == 2'd1 && pop));

  assign push_entry = '{data: fifo_data_i, last: infl_last_q};

  fifo_reader_skid #(.entry_t(entry_t)) u_skid (
    .clk_rd_i     (clk_rd_i),
    .rst_n_i      (rst_n_i),
    .push_i       (infl_q),
    .push_entry_i (push_entry),
    .valid_o      (skid_valid),
    .ready_i      (m_ready_i),
    .head_o       (head),
    .pop_o        (pop),
    .occ_o        (occ)
  );

`ifdef FIFO_READER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt_q;
  logic          timeout_hit;
  logic          err_q;

  assign timeout_hit = (state_q == ST_READ) && fifo_empty_i &&
                       (idle_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_rd_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      // any non-empty cycle (and hence any strobe) restarts the count
      if (state_q != ST_READ || !fifo_empty_i) idle_cnt_q <= '0;
      else                                     idle_cnt_q <= idle_cnt_q + CW'(1);
      if (state_q == ST_IDLE && start_i)      err_q <= 1'b0;
      else if (state_d == ST_ABORT && state_q == ST_READ) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
  // An aborted burst never sees its final strobe, so the last word left
  // in the buffer is tagged instead.
  assign m_last_o = skid_valid &&
                    (head.last || (state_q == ST_ABORT && occ == 2'd1 && !infl_q));
`else
  // TIMEOUT_CYCLES has no effect in this build
  assign err_o    = 1'b0 & (TIMEOUT_CYCLES == 0);
  assign m_last_o = skid_valid && head.last;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_READ;
      ST_READ: begin
        if (rd_o && remain_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
`ifdef FIFO_READER_TIMEOUT_EN
        else if (timeout_hit)                  state_d = ST_ABORT;
`endif
      end
      ST_DRAIN: if (drained) state_d = ST_DONE;
`ifdef FIFO_READER_TIMEOUT_EN
      ST_ABORT: if (drained) state_d = ST_DONE;
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_rd_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      infl_q      <= rd_o;
      infl_last_q <= rd_o && (remain_q == LEN_WIDTH'(1));
      if (state_q == ST_IDLE && start_i) remain_q <= len_i;
      else if (rd_o)                     remain_q <= remain_q - LEN_WIDTH'(1);
    end
  end

  assign oe_o      = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign m_valid_o = skid_valid;
  assign m_data_o  = head.data;

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed + randomized bench for fifo_reader.
// A queue-based FIFO model feeds the DUT; a scoreboard checks stream order,
// last tagging, hold-while-stalled, busy and done timing.
module tb_fifo_reader;
  localparam int DW = 18;
  localparam int LW = 11;
  localparam int TO = 16;

  logic          clk_rd_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          fifo_empty_i = 1'b1;
  logic [DW-1:0] fifo_data_i = '0;
  logic          rd_o, oe_o, m_valid_o, m_last_o, busy_o, done_o, err_o;
  logic          m_ready_i = 1'b0;
  logic [DW-1:0] m_data_o;

  always #5 clk_rd_i = ~clk_rd_i;

  fifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_rd_i(clk_rd_i), .rst_n_i(rst_n_i), .start_i(start_i), .len_i(len_i),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .rd_o(rd_o), .oe_o(oe_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- FIFO model ----------------
  logic [DW-1:0] src_q[$];
  bit            gate = 1'b0;   // forces the FIFO to look empty
  bit            rd_smp = 1'b0; // rd_o as seen mid-cycle

  always @(posedge clk_rd_i) begin
    if (rd_smp) begin
      if (src_q.size() == 0) chk("rd_on_empty", 32'd1, 32'd0);
      else fifo_data_i <= src_q.pop_front();
    end
    fifo_empty_i <= gate || (src_q.size() == 0);
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int  n_rd = 0, pop_idx = 0, last_idx = -1, trunc_len = 1 << 20;
  bit  busy_exp = 1'b0, done_due = 1'b0, prev_hold = 1'b0, accept;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk_rd_i) begin
    rd_smp = rd_o;
    if (!rst_n_i) begin
      busy_exp = 1'b0; done_due = 1'b0; prev_hold = 1'b0; pop_idx = 0;
    end else begin
      if (rd_o) n_rd++;
      chk("busy", 32'(busy_o), 32'(busy_exp));
      if (done_due || done_o) chk("done", 32'(done_o), 32'(done_due));
      if (prev_hold) begin
        chk("hold_vld", 32'(m_valid_o), 32'd1);
        chk("hold_data", 32'(m_data_o), 32'(prev_data));
        chk("hold_last", 32'(m_last_o), 32'(prev_last));
      end
      accept = start_i && !busy_exp;
      if (done_due) busy_exp = 1'b0;
      done_due = 1'b0;
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) chk("extra_word", 32'(m_data_o), 32'hdead_0000);
        else begin
          chk("data", 32'(m_data_o), 32'(exp_q.pop_front()));
          chk("last", 32'(m_last_o), 32'(pop_idx == last_idx));
          if (pop_idx == last_idx) done_due = 1'b1;
          pop_idx++;
        end
      end
      prev_hold = m_valid_o && !m_ready_i;
      prev_data = m_data_o;
      prev_last = m_last_o;
      if (accept) begin
        busy_exp = 1'b1;
        pop_idx  = 0;
        last_idx = ((int'(len_i) < trunc_len) ? int'(len_i) : trunc_len) - 1;
        if (len_i == '0) done_due = 1'b1;
      end
    end
  end

  // ---------------- random background ----------------
  bit rnd_en = 1'b0;
  always @(posedge clk_rd_i) begin
    if (rnd_en) begin
      #1;
      m_ready_i = ($urandom_range(0, 3) != 0);
      gate      = ($urandom_range(0, 4) == 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_rd_i);
    #1;
  endtask

  task automatic load_val(input logic [DW-1:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) load_val(DW'($urandom));
  endtask

  task automatic start(input int n);
    start_i = 1'b1;
    len_i   = LW'(n);
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (i < budget && (busy_o || busy_exp)) begin
      tick();
      i++;
    end
    chk("burst_end", 32'(busy_o || busy_exp), 32'd0);
    chk("words_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd"},    32'(rd_o), 32'd0);
    chk({tag, "_oe"},    32'(oe_o), 32'd0);
    chk({tag, "_vld"},   32'(m_valid_o), 32'd0);
    chk({tag, "_last"},  32'(m_last_o), 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_done"},  32'(done_o), 32'd0);
    chk({tag, "_err"},   32'(err_o), 32'd0);
    chk({tag, "_data"},  32'(m_data_o), 32'd0);
  endtask

  logic [5:0] rdv, vv;
  int r0, n, bad_rd, bad_busy, k;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(2);
    chk_reset_outputs("rst");
    rst_n_i = 1'b1;
    tick();

    // T1: len 4, words 1..4, consumer always ready
    m_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) load_val(DW'(i));
    tick();
    start(4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_rd_i);
      rdv[i] = rd_o;
      vv[i]  = m_valid_o;
    end
    chk("t1_rd_pattern", 32'(rdv), 32'b001111);
    chk("t1_vld_pattern", 32'(vv), 32'b111100);
    #1;
    wait_idle(50);

    // T2: zero length
    r0 = n_rd;
    start(0);
    wait_idle(10);
    chk("t2_no_rd", 32'(n_rd - r0), 32'd0);

    // T3: backpressure for 10 cycles
    m_ready_i = 1'b0;
    load(8);
    tick();
    r0 = n_rd;
    start(8);
    tick(10);
    chk("t3_strobes", 32'(n_rd - r0), 32'd2);
    m_ready_i = 1'b1;
    wait_idle(100);

    // T4: FIFO runs dry after 3 of 6 words
    load(3);
    tick();
    start(6);
    tick(3);
    bad_rd = 0; bad_busy = 0;
    repeat (16) begin
      @(negedge clk_rd_i);
      if (rd_o) bad_rd++;
      if (!busy_o) bad_busy++;
    end
    chk("t4_gap_rd", 32'(bad_rd), 32'd0);
    chk("t4_gap_busy", 32'(bad_busy), 32'd0);
    #1;
    load(3);
    wait_idle(100);

    // T5: async reset mid-burst, then a fresh 2-word burst
    load(6);
    tick();
    start(6);
    tick(2);
    #2 rst_n_i = 1'b0;
    #1 chk_reset_outputs("arst");
    @(negedge clk_rd_i);
    tick();
    src_q.delete();
    exp_q.delete();
    rst_n_i = 1'b1;
    tick();
    load(2);
    tick();
    start(2);
    wait_idle(50);

    // T6: randomized bursts with random backpressure and FIFO stalls
    rnd_en = 1'b1;
    for (int b = 0; b < 12; b++) begin
      n = $urandom_range(1, 24);
      load(n);
      start(n);
      if (n >= 6 && busy_o) begin
        start_i = 1'b1;
        len_i   = LW'($urandom_range(1, 50));
        tick();
        start_i = 1'b0;
      end
      wait_idle(500);
    end
    rnd_en = 1'b0;
    tick();
    gate = 1'b0;
    m_ready_i = 1'b1;
    chk("err_clear_default", 32'(err_o), 32'd0);

`ifdef FIFO_READER_TIMEOUT_EN
    // T7: timeout abort with 2 of 5 words held in the buffer
    tick(2);
    m_ready_i = 1'b0;
    trunc_len = 2;
    load(2);
    tick();
    start(5);
    k = 1;
    while (k < 60) begin
      @(negedge clk_rd_i);
      if (err_o) break;
      k++;
    end
    chk("t7_err", 32'(err_o), 32'd1);
    chk("t7_err_cycle", 32'(k), 32'd19);
    #1;
    m_ready_i = 1'b1;
    wait_idle(50);
    chk("t7_err_sticky", 32'(err_o), 32'd1);
    trunc_len = 1 << 20;
    load(1);
    tick();
    start(1);
    chk("t7_err_cleared", 32'(err_o), 32'd0);
    wait_idle(50);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
